npc_trap_unit: RTL and testbench
================================

// Module: npc_trap_unit
// PURPOSE
//  Parametrised successor to the next-PC logic: holds the architectural PC, computes the next PC and handles control-flow exceptions.
//  Applies RISC-V JALR bit-0 clearing and detects misaligned targets. Supports ECALL trap entry, MRET return and retire/stall gating.
//  Sits between ctrl (npc_op) and instruction memory; pc_o drives the imem address.
// PARAMETERS
//  XLEN       32            datapath/PC width
//  RESET_VEC  32'h0000_0000 PC after reset
//  TRAP_VEC   32'h0000_0100 PC loaded on any trap
//  IALIGN     4             instruction alignment in bytes (4, or 2 for compressed); power of 2
// PORTS
//  clk        in   1     single clock, rising edge
//  rst        in   1     synchronous reset, active-high
//  retire_i   in   1     instruction at pc_o completes this cycle; 0 = stall, PC holds
//  npc_op_i   in   3     000 PLUS4, 001 BRANCH (taken), 010 JAL, 100 JALR, 101 MRET, 110 ECALL
//  imm_i      in   XLEN  extended immediate
//  alu_i      in   XLEN  rs1+imm from ALU (JALR)
//  pc_o       out  XLEN  current PC (registered)
//  npc_o      out  XLEN  combinational next PC if retired now (for rd = PC+4 path / debug)
//  fetch_valid_o out 1   pc_o holds a fetchable instruction
//  trap_o     out  1     one-cycle pulse, trap taken
//  cause_o    out  4     0 = instr addr misaligned, 11 = ECALL; holds last value
//  epc_o      out  XLEN  PC of trapping instruction; MRET return address
//  tval_o     out  XLEN  faulting target (misaligned) or 0 (ECALL)
// BEHAVIOUR
//  Reset: pc_o=RESET_VEC, epc_o=0, cause_o=0, tval_o=0, trap_o=0, fetch_valid_o=0, state=BOOT. rst wins over everything.
//  FSM: BOOT -> RUN (unconditional, 1 cycle, fetch_valid_o=0).
//   RUN: fetch_valid_o=1; on retire_i: if trap condition -> TRAP, else pc_o<=target. No retire_i: all regs hold.
//   TRAP: 1 cycle; pc_o already TRAP_VEC, trap_o=1, fetch_valid_o=0, retire_i ignored; -> RUN.
//  Target: PLUS4 PC+4; BRANCH/JAL PC+imm_i; JALR alu_i & ~1; MRET epc_o; ECALL TRAP_VEC; undefined ops = PLUS4.
//  Arithmetic modulo 2^XLEN: PC+4 at 0xFFFF_FFFC wraps to 0, no trap.
//  Misaligned: target[log2(IALIGN)-1:0]!=0 (checked after bit-0 clear) for BRANCH/JAL/JALR.
//   On retire: epc_o<=PC, cause_o<=0, tval_o<=target, pc_o<=TRAP_VEC, -> TRAP.
//  ECALL on retire: epc_o<=PC, cause_o<=11, tval_o<=0, pc_o<=TRAP_VEC, -> TRAP.
//  MRET does not modify epc_o/cause_o; epc_o is always aligned, so there is no misalign check.
//  npc_o equals the computed target, or TRAP_VEC when a trap condition is present; valid only in RUN.
//  Latency: pc_o updates on the edge where retire_i=1 in RUN; trap_o is asserted the following cycle.
//  Reset asserted in TRAP or mid-stall: next cycle is BOOT with reset values; pending trap is discarded.
// STRUCTURE
//  Shared package npc_pkg: npc_op encodings (NPC_PLUS4..NPC_ECALL), cause codes (CAUSE_IMISALIGN=0, CAUSE_ECALL=11), state enum {BOOT,RUN,TRAP}.
//   ctrl must import the same op constants.
//  Sub-module npc_target_calc (combinational): PC, op, imm, alu, epc -> target, misalign flag.
//  Top holds PC/epc/cause/tval registers and the FSM.
// TESTING
//  Reset: rst=1 two cycles, then release -> pc_o=0, fetch_valid_o=0 one cycle, then 1; trap_o=0.
//  Sequential + stall: PLUS4 retire x3 with retire_i=0 on cycle 2 -> pc_o 0,4,4,8,0xC.
//  JALR clear: PC=0x20, alu_i=0x41, JALR -> pc_o=0x40, no trap. alu_i=0x42 -> trap_o, cause_o=0, tval_o=0x42, epc_o=0x20, pc_o=0x100.
//  ECALL/MRET: PC=0x80 ECALL -> pc_o=0x100, epc_o=0x80, cause_o=11; MRET at 0x100 -> pc_o=0x80.
//  Wrap/branch: PC=0xFFFF_FFFC PLUS4 -> 0, no trap. BRANCH imm=-8 at PC=0x10 -> 0x8. IALIGN=2: JAL imm=6 -> no trap.
//  Reset during TRAP cycle -> next pc_o=RESET_VEC, trap_o=0, epc_o=0.

Source files
------------

// File: rtl/npc_pkg.sv
// Shared next-PC encodings, trap cause codes and sequencer states; also imported by ctrl.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package npc_pkg;

    // npc_op encodings driven by ctrl
    localparam logic [2:0] NPC_PLUS4  = 3'b000;
    localparam logic [2:0] NPC_BRANCH = 3'b001;
    localparam logic [2:0] NPC_JAL    = 3'b010;
    localparam logic [2:0] NPC_JALR   = 3'b100;
    localparam logic [2:0] NPC_MRET   = 3'b101;
    localparam logic [2:0] NPC_ECALL  = 3'b110;

    // mcause-style exception codes
    localparam logic [3:0] CAUSE_IMISALIGN = 4'd0;
    localparam logic [3:0] CAUSE_ECALL     = 4'd11;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        TRAP = 2'd2
    } npc_state_e;

    // Ops whose target comes from program data and so can land misaligned
    function automatic logic is_xfer_op(input logic [2:0] op);
        return (op == NPC_BRANCH) || (op == NPC_JAL) || (op == NPC_JALR);
    endfunction

endpackage

// File: rtl/npc_target_calc.sv
// Next-PC target selection with JALR bit-0 clear and misalignment / ECALL detection.
// Latency: purely combinational, zero cycles.
// Backpressure: none; results are consumed only when the parent retires.
module npc_target_calc
    import npc_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] TRAP_VEC = XLEN'(32'h0000_0100),
    parameter int              IALIGN   = 4
) (
    input  logic [XLEN-1:0] pc,
    input  logic [2:0]      npc_op,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] alu,
    input  logic [XLEN-1:0] epc,
    output logic [XLEN-1:0] target,
    output logic            misalign,
    output logic            ecall
);

    localparam int ALIGN_BITS = $clog2(IALIGN);

    logic [XLEN-1:0] tgt;

    // Select the raw target; unknown encodings behave like sequential flow
    always_comb begin
        tgt = pc + XLEN'(4);
        case (npc_op)
            NPC_BRANCH,
            NPC_JAL:   tgt = pc + imm;
            NPC_JALR:  tgt = alu & ~XLEN'(1);
            NPC_MRET:  tgt = epc;
            NPC_ECALL: tgt = TRAP_VEC;
            default:   tgt = pc + XLEN'(4);
        endcase
    end

    // Flag conditions that divert the retire into a trap; the alignment check sees the bit-0-cleared JALR target
    always_comb begin
        target   = tgt;
        ecall    = (npc_op == NPC_ECALL);
        misalign = is_xfer_op(npc_op) && (tgt[ALIGN_BITS-1:0] != '0);
    end

endmodule

// File: rtl/npc_trap_unit.sv
// Architectural PC register, next-PC selection and trap entry/return sequencing.
// Latency: pc updates on the retiring edge; trap pulse is visible the cycle after.
// Backpressure: retire low stalls every register; BOOT and TRAP cycles ignore retire.
module npc_trap_unit
    import npc_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = XLEN'(32'h0000_0000),
    parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(32'h0000_0100),
    parameter int              IALIGN    = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            retire_i,
    input  logic [2:0]      npc_op_i,
    input  logic [XLEN-1:0] imm_i,
    input  logic [XLEN-1:0] alu_i,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] npc_o,
    output logic            fetch_valid_o,
    output logic            trap_o,
    output logic [3:0]      cause_o,
    output logic [XLEN-1:0] epc_o,
    output logic [XLEN-1:0] tval_o
);

    npc_state_e      state, state_nxt;
    logic [XLEN-1:0] target;
    logic            misalign;
    logic            ecall;
    logic            take_trap;
    logic            advance;

    npc_target_calc #(
        .XLEN     (XLEN),
        .TRAP_VEC (TRAP_VEC),
        .IALIGN   (IALIGN)
    ) u_target_calc (
        .pc       (pc_o),
        .npc_op   (npc_op_i),
        .imm      (imm_i),
        .alu      (alu_i),
        .epc      (epc_o),
        .target   (target),
        .misalign (misalign),
        .ecall    (ecall)
    );

    assign take_trap = misalign | ecall;
    assign advance   = (state == RUN) && retire_i;
    assign npc_o     = take_trap ? TRAP_VEC : target;

    // State register; reset forces BOOT and drops any trap in flight
    always_ff @(posedge clk) begin
        if (rst) state <= BOOT;
        else     state <= state_nxt;
    end

    // Next state: BOOT and TRAP last exactly one cycle, RUN leaves only on a retiring trap
    always_comb begin
        state_nxt = state;
        case (state)
            BOOT:    state_nxt = RUN;
            RUN:     if (advance && take_trap) state_nxt = TRAP;
            TRAP:    state_nxt = RUN;
            default: state_nxt = BOOT;
        endcase
    end

    // State-decoded outputs: fetch only in RUN, trap pulse during the TRAP cycle
    always_comb begin
        fetch_valid_o = (state == RUN);
        trap_o        = (state == TRAP);
    end

    // PC and trap CSRs; MRET only moves the PC, epc/cause stay for a later re-entry
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_o    <= RESET_VEC;
            epc_o   <= '0;
            cause_o <= CAUSE_IMISALIGN;
            tval_o  <= '0;
        end else if (advance) begin
            if (take_trap) begin
                pc_o    <= TRAP_VEC;
                epc_o   <= pc_o;
                cause_o <= ecall ? CAUSE_ECALL : CAUSE_IMISALIGN;
                tval_o  <= ecall ? '0 : target;
            end else begin
                pc_o <= target;
            end
        end
    end

endmodule

// File: tb/tb_npc_trap_unit.sv
// Bench for npc_trap_unit: directed vector table, hand sequences and random stimulus vs a reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_npc_trap_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        retire = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] imm = '0;
    logic [31:0] alu = '0;

    always #5 clk = ~clk;

    // Two builds share the stimulus: word-aligned (index 0) and halfword-aligned (index 1)
    logic [31:0] pc_w [2];
    logic [31:0] npc_w [2];
    logic        fv_w [2];
    logic        trap_w [2];
    logic [3:0]  cause_w [2];
    logic [31:0] epc_w [2];
    logic [31:0] tval_w [2];

    npc_trap_unit #(.XLEN(32), .RESET_VEC(32'h0), .TRAP_VEC(32'h100), .IALIGN(4)) u_dut4 (
        .clk(clk), .rst(rst), .retire_i(retire), .npc_op_i(op), .imm_i(imm), .alu_i(alu),
        .pc_o(pc_w[0]), .npc_o(npc_w[0]), .fetch_valid_o(fv_w[0]), .trap_o(trap_w[0]),
        .cause_o(cause_w[0]), .epc_o(epc_w[0]), .tval_o(tval_w[0]));

    npc_trap_unit #(.XLEN(32), .RESET_VEC(32'h0), .TRAP_VEC(32'h100), .IALIGN(2)) u_dut2 (
        .clk(clk), .rst(rst), .retire_i(retire), .npc_op_i(op), .imm_i(imm), .alu_i(alu),
        .pc_o(pc_w[1]), .npc_o(npc_w[1]), .fetch_valid_o(fv_w[1]), .trap_o(trap_w[1]),
        .cause_o(cause_w[1]), .epc_o(epc_w[1]), .tval_o(tval_w[1]));

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // phase: 0 = booting, 1 = fetching, 2 = announcing a trap
    typedef struct {
        logic [31:0] pc;
        logic [31:0] epc;
        logic [31:0] tval;
        logic [3:0]  cause;
        int          phase;
        bit          valid;
    } mdl_t;

    mdl_t m [2];
    int   ia [2] = '{4, 2};

    function automatic logic [31:0] ref_target(input mdl_t s, input logic [2:0] o,
                                               input logic [31:0] im, input logic [31:0] al);
        case (o)
            3'd1, 3'd2: return s.pc + im;
            3'd4:       return al & 32'hFFFF_FFFE;
            3'd5:       return s.epc;
            3'd6:       return 32'h100;
            default:    return s.pc + 32'd4;
        endcase
    endfunction

    function automatic bit ref_bad(input logic [2:0] o, input logic [31:0] t, input int a);
        return (o == 3'd1 || o == 3'd2 || o == 3'd4) && ((t % a) != 0);
    endfunction

    task automatic ref_clock(input int k);
        logic [31:0] t;
        if (rst) begin
            m[k].pc = 0; m[k].epc = 0; m[k].tval = 0; m[k].cause = 0;
            m[k].phase = 0; m[k].valid = 1;
            return;
        end
        if (!m[k].valid) return;
        if (m[k].phase != 1) begin
            m[k].phase = 1;
            return;
        end
        if (!retire) return;
        t = ref_target(m[k], op, imm, alu);
        if (op == 3'd6) begin
            m[k].epc = m[k].pc; m[k].cause = 11; m[k].tval = 0;
            m[k].pc = 32'h100; m[k].phase = 2;
        end else if (ref_bad(op, t, ia[k])) begin
            m[k].epc = m[k].pc; m[k].cause = 0; m[k].tval = t;
            m[k].pc = 32'h100; m[k].phase = 2;
        end else begin
            m[k].pc = t;
        end
    endtask

    task automatic check_npc(input int k);
        logic [31:0] t;
        logic [31:0] e;
        if (m[k].valid && m[k].phase == 1) begin
            t = ref_target(m[k], op, imm, alu);
            e = (op == 3'd6 || ref_bad(op, t, ia[k])) ? 32'h100 : t;
            chk($sformatf("model%0d.npc", ia[k]), npc_w[k], e);
        end
    endtask

    task automatic check_model(input int k);
        if (!m[k].valid) return;
        chk($sformatf("model%0d.pc", ia[k]), pc_w[k], m[k].pc);
        chk($sformatf("model%0d.fetch_valid", ia[k]), 32'(fv_w[k]), 32'(m[k].phase == 1));
        chk($sformatf("model%0d.trap", ia[k]), 32'(trap_w[k]), 32'(m[k].phase == 2));
        chk($sformatf("model%0d.cause", ia[k]), 32'(cause_w[k]), 32'(m[k].cause));
        chk($sformatf("model%0d.epc", ia[k]), epc_w[k], m[k].epc);
        chk($sformatf("model%0d.tval", ia[k]), tval_w[k], m[k].tval);
    endtask

    // One clock: drive, check combinational npc, clock, check registered outputs
    task automatic cyc(input bit r, input bit rt, input logic [2:0] o,
                       input logic [31:0] im, input logic [31:0] al);
        rst = r; retire = rt; op = o; imm = im; alu = al;
        #1;
        for (int k = 0; k < 2; k++) check_npc(k);
        @(posedge clk);
        for (int k = 0; k < 2; k++) ref_clock(k);
        #1;
        for (int k = 0; k < 2; k++) check_model(k);
    endtask

    // ---------------- directed vector table (word-aligned build) ----------------
    typedef struct {
        bit          r;
        bit          rt;
        logic [2:0]  o;
        logic [31:0] im;
        logic [31:0] al;
        logic [31:0] pc;
        bit          fv;
        bit          tr;
        logic [3:0]  cause;
        logic [31:0] epc;
        logic [31:0] tval;
    } vec_t;

    function automatic vec_t v(input bit r, input bit rt, input logic [2:0] o,
                               input logic [31:0] im, input logic [31:0] al,
                               input logic [31:0] pc, input bit fv, input bit tr,
                               input logic [3:0] cause, input logic [31:0] epc,
                               input logic [31:0] tval);
        vec_t x;
        x.r = r; x.rt = rt; x.o = o; x.im = im; x.al = al; x.pc = pc;
        x.fv = fv; x.tr = tr; x.cause = cause; x.epc = epc; x.tval = tval;
        return x;
    endfunction

    vec_t tbl [$];

    initial begin
        //                r  rt op    imm           alu           pc            fv tr cause epc      tval
        tbl.push_back(v(1, 0, 3'd0, 32'h0,        32'h0,        32'h0,        0, 0, 0,  32'h0,  32'h0));
        tbl.push_back(v(1, 1, 3'd0, 32'h0,        32'h0,        32'h0,        0, 0, 0,  32'h0,  32'h0));
        tbl.push_back(v(0, 1, 3'd0, 32'h0,        32'h0,        32'h0,        1, 0, 0,  32'h0,  32'h0));
        tbl.push_back(v(0, 1, 3'd0, 32'h0,        32'h0,        32'h4,        1, 0, 0,  32'h0,  32'h0));
        tbl.push_back(v(0, 0, 3'd0, 32'h0,        32'h0,        32'h4,        1, 0, 0,  32'h0,  32'h0));
        tbl.push_back(v(0, 1, 3'd0, 32'h0,        32'h0,        32'h8,        1, 0, 0,  32'h0,  32'h0));
        tbl.push_back(v(0, 1, 3'd0, 32'h0,        32'h0,        32'hC,        1, 0, 0,  32'h0,  32'h0));
        tbl.push_back(v(0, 1, 3'd2, 32'h14,       32'h0,        32'h20,       1, 0, 0,  32'h0,  32'h0));
        tbl.push_back(v(0, 1, 3'd4, 32'h0,        32'h41,       32'h40,       1, 0, 0,  32'h0,  32'h0));
        tbl.push_back(v(0, 1, 3'd2, 32'hFFFF_FFE0, 32'h0,       32'h20,       1, 0, 0,  32'h0,  32'h0));
        tbl.push_back(v(0, 1, 3'd4, 32'h0,        32'h42,       32'h100,      0, 1, 0,  32'h20, 32'h42));
        tbl.push_back(v(0, 1, 3'd0, 32'h0,        32'h0,        32'h100,      1, 0, 0,  32'h20, 32'h42));
        tbl.push_back(v(0, 1, 3'd2, 32'hFFFF_FF80, 32'h0,       32'h80,       1, 0, 0,  32'h20, 32'h42));
        tbl.push_back(v(0, 1, 3'd6, 32'h0,        32'h0,        32'h100,      0, 1, 11, 32'h80, 32'h0));
        tbl.push_back(v(0, 1, 3'd5, 32'h0,        32'h0,        32'h100,      1, 0, 11, 32'h80, 32'h0));
        tbl.push_back(v(0, 1, 3'd5, 32'h0,        32'h0,        32'h80,       1, 0, 11, 32'h80, 32'h0));
        tbl.push_back(v(0, 1, 3'd4, 32'h0,        32'hFFFF_FFFC, 32'hFFFF_FFFC, 1, 0, 11, 32'h80, 32'h0));
        tbl.push_back(v(0, 1, 3'd0, 32'h0,        32'h0,        32'h0,        1, 0, 11, 32'h80, 32'h0));
        tbl.push_back(v(0, 1, 3'd2, 32'h10,       32'h0,        32'h10,       1, 0, 11, 32'h80, 32'h0));
        tbl.push_back(v(0, 1, 3'd1, 32'hFFFF_FFF8, 32'h0,       32'h8,        1, 0, 11, 32'h80, 32'h0));
        tbl.push_back(v(0, 1, 3'd3, 32'h40,       32'h0,        32'hC,        1, 0, 11, 32'h80, 32'h0));
        tbl.push_back(v(0, 1, 3'd7, 32'h40,       32'h0,        32'h10,       1, 0, 11, 32'h80, 32'h0));
        tbl.push_back(v(0, 1, 3'd1, 32'h2,        32'h0,        32'h100,      0, 1, 0,  32'h10, 32'h12));
        tbl.push_back(v(1, 1, 3'd0, 32'h0,        32'h0,        32'h0,        0, 0, 0,  32'h0,  32'h0));
        tbl.push_back(v(0, 0, 3'd0, 32'h0,        32'h0,        32'h0,        1, 0, 0,  32'h0,  32'h0));
        tbl.push_back(v(0, 1, 3'd2, 32'h40,       32'h0,        32'h40,       1, 0, 0,  32'h0,  32'h0));
        tbl.push_back(v(1, 0, 3'd0, 32'h0,        32'h0,        32'h0,        0, 0, 0,  32'h0,  32'h0));
        tbl.push_back(v(0, 0, 3'd0, 32'h0,        32'h0,        32'h0,        1, 0, 0,  32'h0,  32'h0));

        for (int i = 0; i < tbl.size(); i++) begin
            cyc(tbl[i].r, tbl[i].rt, tbl[i].o, tbl[i].im, tbl[i].al);
            chk($sformatf("tbl[%0d].pc", i), pc_w[0], tbl[i].pc);
            chk($sformatf("tbl[%0d].fetch_valid", i), 32'(fv_w[0]), 32'(tbl[i].fv));
            chk($sformatf("tbl[%0d].trap", i), 32'(trap_w[0]), 32'(tbl[i].tr));
            chk($sformatf("tbl[%0d].cause", i), 32'(cause_w[0]), 32'(tbl[i].cause));
            chk($sformatf("tbl[%0d].epc", i), epc_w[0], tbl[i].epc);
            chk($sformatf("tbl[%0d].tval", i), tval_w[0], tbl[i].tval);
        end

        // Halfword alignment: JAL +6 is legal there but traps in the word-aligned build
        cyc(1, 0, 3'd0, 32'h0, 32'h0);
        cyc(0, 0, 3'd0, 32'h0, 32'h0);
        rst = 0; retire = 1; op = 3'd2; imm = 32'h6; alu = 32'h0;
        #1;
        chk("ialign2.npc_jal6", npc_w[1], 32'h6);
        chk("ialign4.npc_jal6", npc_w[0], 32'h100);
        cyc(0, 1, 3'd2, 32'h6, 32'h0);
        chk("ialign2.pc_jal6", pc_w[1], 32'h6);
        chk("ialign2.trap_jal6", 32'(trap_w[1]), 32'h0);
        chk("ialign4.trap_jal6", 32'(trap_w[0]), 32'h1);
        chk("ialign4.tval_jal6", tval_w[0], 32'h6);
        cyc(0, 1, 3'd4, 32'h0, 32'h43);
        chk("ialign2.pc_jalr43", pc_w[1], 32'h42);
        chk("ialign2.trap_jalr43", 32'(trap_w[1]), 32'h0);
        chk("ialign4.pc_after_trap", pc_w[0], 32'h100);

        // Random traffic against the reference model
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] ri;
            logic [31:0] ra;
            ri = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'h0000_0FFC);
            ra = ($urandom_range(0, 1) == 0) ? $urandom : ($urandom & 32'h0000_0FFF);
            cyc($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
                3'($urandom_range(0, 7)), ri, ra);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
